n64_controller_rx: RTL and testbench
====================================

N64_CONTROLLER_RX -- requirements
Module: n64_controller_rx

Interface
REQ-001 SHALL have parameter LEVEL_WIDTH, default 2, meaning sample_clk cycles per Joybus level; BIT_WIDTH = 4*LEVEL_WIDTH is derived, not a separate parameter.
REQ-002 SHALL have port sample_clk  in  1  the single clock; all logic runs on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port cur_operation  in  1  0 = Rx owns the line, 1 = Tx owns it.
REQ-005 SHALL have port data_rx  in  1  Joybus line, asynchronous, idles high.
REQ-006 SHALL have port cmd  out  8  last received command byte.
REQ-007 SHALL have port addr  out  16  last received address, for commands 0x02 and 0x03.
REQ-008 SHALL have port data_byte  out  8  write-payload byte.
REQ-009 SHALL have port data_valid  out  1  one-cycle strobe qualifying data_byte.
REQ-010 SHALL have port data_index  out  5  payload byte index, 0 to 31.
REQ-011 SHALL have port data_crc  out  8  unflushed CRC remainder of the 256 payload bits.
REQ-012 SHALL have port tx_handoff  out  1  toggles once per good frame.
REQ-013 SHALL have port rx_error  out  1  one-cycle strobe on a framing error.

Function
REQ-014 SHALL pass data_rx through a 2-flop synchronizer; all timing below is relative to the synchronized signal.
REQ-015 SHALL start a bit on a synchronized falling edge, then sample the line exactly 2*LEVEL_WIDTH cycles later: low -> 0, high -> 1.
REQ-016 SHALL shift bits MSB-first.
REQ-017 SHALL re-arm for the next falling edge only after the line has been seen high.
REQ-018 SHALL use states IDLE, CMD, ADDR, DATA, STOP, HANDOFF.
REQ-019 SHALL move IDLE -> CMD on the first falling edge while cur_operation=0.
REQ-020 SHALL, after 8 CMD bits, register cmd, then go to ADDR if cmd is 0x02 or 0x03, else go to STOP; unknown command values also go to STOP.
REQ-021 SHALL, after 16 ADDR bits, register addr, then go to DATA if cmd=0x03, else go to STOP.
REQ-022 SHALL in DATA, after every 8th bit, drive data_byte, pulse data_valid and drive data_index (0..31, wrapping to 0 for the next frame).
REQ-023 SHALL leave DATA for STOP after 256 bits.
REQ-024 SHALL feed every DATA bit into a CRC with polynomial 0x85, initialized to 0x00, no zero flush (the transmitter appends the 8 zero bits).
REQ-025 SHALL register data_crc on entry to STOP.
REQ-026 SHALL accept a stop bit on the next falling edge when the mid-sample reads high, then go to HANDOFF.
REQ-027 SHALL treat a stop bit whose mid-sample reads low as an error.
REQ-028 SHALL in HANDOFF toggle tx_handoff exactly once, then go to IDLE the following cycle.
REQ-029 SHALL treat a low run of BIT_WIDTH cycles or more as an error.
REQ-030 SHALL treat a high run of 2*BIT_WIDTH cycles or more outside IDLE as an error.
REQ-031 SHALL on any error pulse rx_error, go to IDLE, leave tx_handoff unchanged and keep the previous cmd/addr/data_crc.
REQ-032 SHALL force IDLE and ignore data_rx whenever cur_operation=1, including mid-frame; no rx_error is raised in that case.
REQ-033 SHALL give the error path priority when a falling edge and a timeout coincide.

Reset
REQ-034 SHALL, while reset_n=0, hold state=IDLE, all counters 0, synchronizer flops 1, and cmd, addr, data_byte, data_valid, data_index, data_crc, tx_handoff and rx_error all 0.
REQ-035 SHALL discard any partial frame on reset and produce no handoff for it.

Structure
REQ-036 SHALL take the state encodings, command codes (0x00, 0x01, 0x02, 0x03, 0xFF), frame lengths (8/16/256) and CRC polynomial from a shared package n64_joybus_pkg, which the transmitter also uses.
REQ-037 SHALL implement edge detection, the level counter, mid-sampling and timeouts in one sub-module n64_bit_sampler, which outputs bit_valid, bit_value and timeout.
REQ-038 SHALL reuse generate_crc for the CRC.

Verification
REQ-039 Command 0x01 followed by a stop bit -> cmd=0x01, tx_handoff toggles once, no data_valid.
REQ-040 Command 0x02 with address 0x8001 and a stop bit -> addr=0x8001, one toggle.
REQ-041 Command 0x03 with address 0xC01B, 32 bytes 0x00..0x1F and a stop bit -> 32 data_valid strobes with matching data_index and data_byte, data_crc equal to the model remainder, one toggle.
REQ-042 Line held low 20 cycles (LEVEL_WIDTH=2) mid-CMD -> rx_error strobe, return to IDLE, no toggle.
REQ-043 cur_operation raised, or reset_n asserted, after 12 command bits -> IDLE, no toggle, no rx_error; a following clean 0x00 frame decodes normally.

Source files
------------

// File: rtl/n64_joybus_pkg.sv
// ----------------------------------------------------------------------------
// n64_joybus_pkg
// Definitions shared by the Joybus receiver and transmitter:
//   - frame FSM state encodings
//   - command codes
//   - field lengths in bits
//   - CRC polynomial and the single-bit CRC step, generate_crc()
// ----------------------------------------------------------------------------
package n64_joybus_pkg;

   // Frame FSM states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CMD     = 3'd1;
   localparam logic [2:0] ST_ADDR    = 3'd2;
   localparam logic [2:0] ST_DATA    = 3'd3;
   localparam logic [2:0] ST_STOP    = 3'd4;
   localparam logic [2:0] ST_HANDOFF = 3'd5;

   // Command codes
   localparam logic [7:0] CMD_INFO   = 8'h00;
   localparam logic [7:0] CMD_STATUS = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] CMD_WRITE  = 8'h03;
   localparam logic [7:0] CMD_RESET  = 8'hFF;

   // Field lengths in bits
   localparam int CMD_BITS  = 8;
   localparam int ADDR_BITS = 16;
   localparam int DATA_BITS = 256;

   // x^8 + x^7 + x^2 + 1; the x^8 term is implicit
   localparam logic [7:0] CRC_POLY = 8'h85;

   // One shift of the augmented CRC register. The message bit enters at the
   // bottom, so the register holds the remainder of the bits seen so far.
   // Flushing with 8 zero bits is left to the transmitter.
   function automatic logic [7:0] generate_crc(input logic [7:0] crc,
                                               input logic       bit_in);
      generate_crc = {crc[6:0], bit_in} ^ (crc[7] ? CRC_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/n64_bit_sampler.sv
// ----------------------------------------------------------------------------
// n64_bit_sampler
// Recovers Joybus bits from the synchronized line.
// A bit starts on a falling edge. The line is then sampled 2*LEVEL_WIDTH
// cycles later: low gives 0, high gives 1.
//
// Ports:
//   sample_clk  clock
//   reset_n     asynchronous active-low reset
//   enable      0 clears all tracking (the transmitter owns the line)
//   active      frame in progress; this qualifies the long-high timeout
//   line        synchronized Joybus line
//   bit_start   falling edge accepted; a bit starts this cycle
//   bit_valid   mid-bit sample strobe
//   bit_value   sampled level, qualified by bit_valid
//   timeout     low run >= BIT_WIDTH, or high run >= 2*BIT_WIDTH while active
// ----------------------------------------------------------------------------
module n64_bit_sampler
   import n64_joybus_pkg::*;
#(
   parameter int LEVEL_WIDTH = 2
) (
   input  logic sample_clk,
   input  logic reset_n,
   input  logic enable,
   input  logic active,
   input  logic line,
   output logic bit_start,
   output logic bit_valid,
   output logic bit_value,
   output logic timeout
);

   localparam int BIT_WIDTH  = 4 * LEVEL_WIDTH;
   localparam int MID        = 2 * LEVEL_WIDTH;
   localparam int HIGH_LIMIT = 2 * BIT_WIDTH;
   localparam int CW         = $clog2(HIGH_LIMIT + 1);

   localparam logic [CW-1:0] MID_C       = CW'(MID);
   localparam logic [CW-1:0] LOW_SAT     = CW'(BIT_WIDTH);
   localparam logic [CW-1:0] LOW_FIRE    = CW'(BIT_WIDTH - 1);
   localparam logic [CW-1:0] HIGH_SAT    = CW'(HIGH_LIMIT);
   localparam logic [CW-1:0] HIGH_FIRE   = CW'(HIGH_LIMIT - 1);

   logic          armed_q;     // line seen high since the last bit start
   logic          busy_q;
   logic [CW-1:0] phase_q;     // cycles since the bit's falling edge
   logic [CW-1:0] low_run_q;
   logic [CW-1:0] high_run_q;

   logic mid;

   // armed_q tracks the previous level, so a start needs a high-to-low
   // transition. This is the re-arm rule: high must be seen again first.
   assign bit_start = enable & armed_q & ~line;
   assign mid       = busy_q & (phase_q == MID_C);
   assign bit_valid = enable & mid;
   assign bit_value = line;

   // Each timeout fires on the single cycle its run reaches the limit.
   // The run counters then saturate, so one long run gives one strobe.
   assign timeout = enable & ((~line & (low_run_q == LOW_FIRE)) |
                              (line & active & (high_run_q == HIGH_FIRE)));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register in this block sees the values from before the edge.
   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_q    <= 1'b1;
         busy_q     <= 1'b0;
         phase_q    <= '0;
         low_run_q  <= '0;
         high_run_q <= '0;
      end else begin
         armed_q <= line;
         if (!enable) begin
            busy_q     <= 1'b0;
            phase_q    <= '0;
            low_run_q  <= '0;
            high_run_q <= '0;
         end else begin
            if (bit_start) begin
               busy_q  <= 1'b1;
               phase_q <= CW'(1);
            end else if (mid) begin
               busy_q  <= 1'b0;
               phase_q <= '0;
            end else if (busy_q) begin
               phase_q <= phase_q + CW'(1);
            end

            if (line)
               low_run_q <= '0;
            else if (low_run_q != LOW_SAT)
               low_run_q <= low_run_q + CW'(1);

            if (!line)
               high_run_q <= '0;
            else if (high_run_q != HIGH_SAT)
               high_run_q <= high_run_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/n64_controller_rx.sv
// ----------------------------------------------------------------------------
// n64_controller_rx
// Joybus frame receiver. It decodes the command byte. For read and write
// commands it also decodes the 16-bit address. For writes it decodes the
// 32-byte payload and keeps its CRC. After a good stop bit it toggles
// tx_handoff.
//
// Ports:
//   sample_clk     clock
//   reset_n        asynchronous active-low reset
//   cur_operation  0 = receiver owns the line, 1 = transmitter owns it
//   data_rx        asynchronous Joybus line, idles high
//   cmd            last received command byte
//   addr           last received address (commands 0x02 and 0x03)
//   data_byte      payload byte, qualified by data_valid
//   data_valid     one-cycle payload byte strobe
//   data_index     payload byte index, 0..31
//   data_crc       unflushed CRC remainder of the 256 payload bits
//   tx_handoff     toggles once per good frame
//   rx_error       one-cycle framing error strobe
// ----------------------------------------------------------------------------
module n64_controller_rx
   import n64_joybus_pkg::*;
#(
   parameter int LEVEL_WIDTH = 2
) (
   input  logic        sample_clk,
   input  logic        reset_n,
   input  logic        cur_operation,
   input  logic        data_rx,
   output logic [7:0]  cmd,
   output logic [15:0] addr,
   output logic [7:0]  data_byte,
   output logic        data_valid,
   output logic [4:0]  data_index,
   output logic [7:0]  data_crc,
   output logic        tx_handoff,
   output logic        rx_error
);

   localparam logic [8:0] CMD_LAST  = 9'(CMD_BITS - 1);
   localparam logic [8:0] ADDR_LAST = 9'(ADDR_BITS - 1);
   localparam logic [8:0] DATA_LAST = 9'(DATA_BITS - 1);

   // NOTE: two flops before any logic looks at data_rx; only sync2_q is used.
   logic sync1_q, sync2_q;

   logic [2:0]  state_q,      state_d;
   logic [8:0]  bit_cnt_q,    bit_cnt_d;
   logic [15:0] shift_q,      shift_d;
   logic [7:0]  crc_q,        crc_d;
   logic [4:0]  byte_idx_q,   byte_idx_d;
   logic [7:0]  cmd_q,        cmd_d;
   logic [15:0] addr_q,       addr_d;
   logic [7:0]  data_byte_q,  data_byte_d;
   logic        data_valid_q, data_valid_d;
   logic [4:0]  data_index_q, data_index_d;
   logic [7:0]  data_crc_q,   data_crc_d;
   logic        tx_handoff_q, tx_handoff_d;
   logic        rx_error_q,   rx_error_d;

   logic        bit_start, bit_valid, bit_value, timeout;
   logic [15:0] shift_next;
   logic [7:0]  crc_next;

   n64_bit_sampler #(.LEVEL_WIDTH(LEVEL_WIDTH)) u_sampler (
      .sample_clk (sample_clk),
      .reset_n    (reset_n),
      .enable     (~cur_operation),
      .active     (state_q != ST_IDLE),
      .line       (sync2_q),
      .bit_start  (bit_start),
      .bit_valid  (bit_valid),
      .bit_value  (bit_value),
      .timeout    (timeout)
   );

   assign shift_next = {shift_q[14:0], bit_value};
   assign crc_next   = generate_crc(crc_q, bit_value);

   // NOTE: every _d gets its hold value first, so no branch can infer a latch.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      crc_d        = crc_q;
      byte_idx_d   = byte_idx_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      data_byte_d  = data_byte_q;
      data_valid_d = 1'b0;
      data_index_d = data_index_q;
      data_crc_d   = data_crc_q;
      tx_handoff_d = tx_handoff_q;
      rx_error_d   = 1'b0;

      if (cur_operation) begin
         // Transmitter owns the line. Abandon the frame silently.
         state_d = ST_IDLE;
      end else if (timeout) begin
         // Error has priority over any edge or sample in the same cycle.
         rx_error_d = 1'b1;
         state_d    = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bit_start) begin
                  state_d    = ST_CMD;
                  bit_cnt_d  = '0;
                  crc_d      = '0;
                  byte_idx_d = '0;
               end
            end
            ST_CMD: begin
               if (bit_valid) begin
                  shift_d   = shift_next;
                  bit_cnt_d = bit_cnt_q + 9'd1;
                  if (bit_cnt_q == CMD_LAST) begin
                     cmd_d     = shift_next[7:0];
                     bit_cnt_d = '0;
                     case (shift_next[7:0])
                        CMD_READ, CMD_WRITE:            state_d = ST_ADDR;
                        CMD_INFO, CMD_STATUS, CMD_RESET: state_d = ST_STOP;
                        default:                         state_d = ST_STOP;
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (bit_valid) begin
                  shift_d   = shift_next;
                  bit_cnt_d = bit_cnt_q + 9'd1;
                  if (bit_cnt_q == ADDR_LAST) begin
                     addr_d    = shift_next;
                     bit_cnt_d = '0;
                     state_d   = (cmd_q == CMD_WRITE) ? ST_DATA : ST_STOP;
                  end
               end
            end
            ST_DATA: begin
               if (bit_valid) begin
                  shift_d   = shift_next;
                  crc_d     = crc_next;
                  bit_cnt_d = bit_cnt_q + 9'd1;
                  if (bit_cnt_q[2:0] == 3'd7) begin
                     data_byte_d  = shift_next[7:0];
                     data_valid_d = 1'b1;
                     data_index_d = byte_idx_q;
                     byte_idx_d   = byte_idx_q + 5'd1;
                  end
                  if (bit_cnt_q == DATA_LAST) begin
                     data_crc_d = crc_next;
                     bit_cnt_d  = '0;
                     state_d    = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (bit_valid) begin
                  state_d    = bit_value ? ST_HANDOFF : ST_IDLE;
                  rx_error_d = ~bit_value;
               end
            end
            ST_HANDOFF: begin
               tx_handoff_d = ~tx_handoff_q;
               state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         crc_q        <= '0;
         byte_idx_q   <= '0;
         cmd_q        <= '0;
         addr_q       <= '0;
         data_byte_q  <= '0;
         data_valid_q <= 1'b0;
         data_index_q <= '0;
         data_crc_q   <= '0;
         tx_handoff_q <= 1'b0;
         rx_error_q   <= 1'b0;
      end else begin
         sync1_q      <= data_rx;
         sync2_q      <= sync1_q;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         crc_q        <= crc_d;
         byte_idx_q   <= byte_idx_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         data_byte_q  <= data_byte_d;
         data_valid_q <= data_valid_d;
         data_index_q <= data_index_d;
         data_crc_q   <= data_crc_d;
         tx_handoff_q <= tx_handoff_d;
         rx_error_q   <= rx_error_d;
      end
   end

   assign cmd        = cmd_q;
   assign addr       = addr_q;
   assign data_byte  = data_byte_q;
   assign data_valid = data_valid_q;
   assign data_index = data_index_q;
   assign data_crc   = data_crc_q;
   assign tx_handoff = tx_handoff_q;
   assign rx_error   = rx_error_q;

endmodule

// File: tb/tb_n64_controller_rx.sv
// ----------------------------------------------------------------------------
// tb_n64_controller_rx
// Directed bench for n64_controller_rx with LEVEL_WIDTH = 2.
// Stimulus is driven on the falling clock edge. Payload expectations are
// queued as the bytes are sent. A monitor pops and compares them on each
// data_valid strobe, and also counts tx_handoff toggles and rx_error pulses.
// ----------------------------------------------------------------------------
module tb_n64_controller_rx;

   localparam int LW = 2;

   logic        sample_clk = 1'b0;
   logic        reset_n;
   logic        cur_operation;
   logic        data_rx;
   logic [7:0]  cmd;
   logic [15:0] addr;
   logic [7:0]  data_byte;
   logic        data_valid;
   logic [4:0]  data_index;
   logic [7:0]  data_crc;
   logic        tx_handoff;
   logic        rx_error;

   n64_controller_rx #(.LEVEL_WIDTH(LW)) dut (
      .sample_clk    (sample_clk),
      .reset_n       (reset_n),
      .cur_operation (cur_operation),
      .data_rx       (data_rx),
      .cmd           (cmd),
      .addr          (addr),
      .data_byte     (data_byte),
      .data_valid    (data_valid),
      .data_index    (data_index),
      .data_crc      (data_crc),
      .tx_handoff    (tx_handoff),
      .rx_error      (rx_error)
   );

   always #5 sample_clk = ~sample_clk;

   typedef struct packed {
      logic [4:0] idx;
      logic [7:0] val;
   } dv_t;

   dv_t  exp_q[$];
   dv_t  mon_e;
   int   checks = 0;
   int   errors = 0;
   int   dv_seen = 0;
   int   toggles = 0;
   int   err_pulses = 0;
   logic prev_handoff = 1'b0;

   int   t0, e0, d0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge sample_clk) begin
      if (reset_n) begin
         if (data_valid) begin
            dv_seen++;
            check("dv_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("data_index", 32'(data_index), 32'(mon_e.idx));
               check("data_byte",  32'(data_byte),  32'(mon_e.val));
            end
         end
         if (tx_handoff !== prev_handoff) toggles++;
         if (rx_error) err_pulses++;
      end
      prev_handoff = tx_handoff;
   end

   // Line drivers. Each one is called at a falling edge and returns at one.
   task automatic hold(input logic lvl, input int n);
      data_rx = lvl;
      repeat (n) @(negedge sample_clk);
   endtask

   task automatic send_bit(input logic b);
      hold(1'b0, b ? LW : 3 * LW);
      hold(1'b1, b ? 3 * LW : LW);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic snap();
      t0 = toggles;
      e0 = err_pulses;
      d0 = dv_seen;
   endtask

   // Unflushed remainder by polynomial long division of the payload 0x00..0x1F
   function automatic logic [7:0] crc_model();
      logic [255:0] m;
      for (int k = 0; k < 32; k++) m[255 - 8 * k -: 8] = 8'(k);
      for (int i = 255; i >= 8; i--)
         if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h185;
      return m[7:0];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n       = 1'b0;
      cur_operation = 1'b0;
      data_rx       = 1'b1;
      repeat (3) @(negedge sample_clk);

      // Reset values
      check("rst_cmd",        32'(cmd),        32'h0);
      check("rst_addr",       32'(addr),       32'h0);
      check("rst_data_byte",  32'(data_byte),  32'h0);
      check("rst_data_valid", 32'(data_valid), 32'h0);
      check("rst_data_index", 32'(data_index), 32'h0);
      check("rst_data_crc",   32'(data_crc),   32'h0);
      check("rst_tx_handoff", 32'(tx_handoff), 32'h0);
      check("rst_rx_error",   32'(rx_error),   32'h0);
      reset_n = 1'b1;
      hold(1'b1, 10);

      // Status command, no address
      snap();
      send_bits(32'h01, 8); send_bit(1'b1); hold(1'b1, 20);
      check("c01_cmd",    32'(cmd), 32'h01);
      check("c01_toggle", 32'(toggles - t0), 32'd1);
      check("c01_err",    32'(err_pulses - e0), 32'd0);
      check("c01_dv",     32'(dv_seen - d0), 32'd0);

      // Read command with address
      snap();
      send_bits(32'h02, 8); send_bits(32'h8001, 16); send_bit(1'b1); hold(1'b1, 20);
      check("c02_cmd",    32'(cmd), 32'h02);
      check("c02_addr",   32'(addr), 32'h8001);
      check("c02_toggle", 32'(toggles - t0), 32'd1);

      // Write command with 32-byte payload
      snap();
      send_bits(32'h03, 8); send_bits(32'hC01B, 16);
      for (int k = 0; k < 32; k++) begin
         exp_q.push_back('{idx: 5'(k), val: 8'(k)});
         send_bits(32'(k), 8);
      end
      send_bit(1'b1); hold(1'b1, 20);
      check("c03_cmd",     32'(cmd), 32'h03);
      check("c03_addr",    32'(addr), 32'hC01B);
      check("c03_dv",      32'(dv_seen - d0), 32'd32);
      check("c03_q_empty", 32'(exp_q.size()), 32'd0);
      check("c03_crc",     32'(data_crc), 32'(crc_model()));
      check("c03_toggle",  32'(toggles - t0), 32'd1);
      check("c03_err",     32'(err_pulses - e0), 32'd0);

      // Unknown command goes straight to the stop bit
      snap();
      send_bits(32'hA5, 8); send_bit(1'b1); hold(1'b1, 20);
      check("cA5_cmd",    32'(cmd), 32'hA5);
      check("cA5_toggle", 32'(toggles - t0), 32'd1);

      // Line stuck low mid-command
      snap();
      send_bits(32'b101, 3); hold(1'b0, 20); hold(1'b1, 20);
      check("low_err",    32'(err_pulses - e0), 32'd1);
      check("low_toggle", 32'(toggles - t0), 32'd0);
      check("low_cmd",    32'(cmd), 32'hA5);

      // Stop bit sampled low
      snap();
      send_bits(32'h01, 8); send_bit(1'b0); hold(1'b1, 20);
      check("stop_err",    32'(err_pulses - e0), 32'd1);
      check("stop_toggle", 32'(toggles - t0), 32'd0);
      check("stop_cmd",    32'(cmd), 32'h01);

      // Line stuck high mid-address
      snap();
      send_bits(32'h02, 8); hold(1'b1, 20); hold(1'b1, 10);
      check("high_err",    32'(err_pulses - e0), 32'd1);
      check("high_toggle", 32'(toggles - t0), 32'd0);
      check("high_addr",   32'(addr), 32'hC01B);

      // Transmitter takes the line after 12 bits, then a clean 0x00 frame
      snap();
      send_bits(32'h02, 8); send_bits(32'hA, 4);
      cur_operation = 1'b1;
      send_bits(32'h00, 8); hold(1'b0, 20); hold(1'b1, 4);
      cur_operation = 1'b0;
      hold(1'b1, 20);
      check("own_err",    32'(err_pulses - e0), 32'd0);
      check("own_toggle", 32'(toggles - t0), 32'd0);
      check("own_addr",   32'(addr), 32'hC01B);
      snap();
      send_bits(32'h00, 8); send_bit(1'b1); hold(1'b1, 20);
      check("own_c00_cmd",    32'(cmd), 32'h00);
      check("own_c00_toggle", 32'(toggles - t0), 32'd1);
      check("own_c00_err",    32'(err_pulses - e0), 32'd0);

      // Reset after 12 bits, then a clean 0x00 frame
      send_bits(32'h01, 8); send_bit(1'b1); hold(1'b1, 20);
      snap();
      send_bits(32'h02, 8); send_bits(32'hA, 4);
      reset_n = 1'b0;
      hold(1'b1, 3);
      check("rst2_cmd",     32'(cmd), 32'h0);
      check("rst2_addr",    32'(addr), 32'h0);
      check("rst2_handoff", 32'(tx_handoff), 32'h0);
      reset_n = 1'b1;
      hold(1'b1, 20);
      check("rst2_err",    32'(err_pulses - e0), 32'd0);
      check("rst2_toggle", 32'(toggles - t0), 32'd0);
      snap();
      send_bits(32'h00, 8); send_bit(1'b1); hold(1'b1, 20);
      check("rst2_c00_toggle", 32'(toggles - t0), 32'd1);
      check("rst2_c00_err",    32'(err_pulses - e0), 32'd0);
      check("rst2_c00_hand",   32'(tx_handoff), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
